// File: rtl/cpu_pkg.sv
// Shared constants and types for the N-to-1 arbitrated output mux.
package cpu_pkg;

  localparam int DWIDTH_DEF = 32;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle between NCH producers, the arbitrated mux and one consumer.
// master = producer/consumer side, slave = the mux itself.
interface mux_arb_nto1_if #(
  parameter int DWIDTH = cpu_pkg::DWIDTH_DEF,
  parameter int NCH    = 4
) ();
  localparam int SELW = $clog2(NCH);

  logic [NCH*DWIDTH-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic                  mode;
  logic [DWIDTH-1:0]     out_data;
  logic [SELW-1:0]       out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, mode, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arbiter_nch.sv
// Combinational one-hot arbiter: fixed lowest-index priority or round-robin from ptr.
// Zero latency; grant is all-zero when nothing requests.
module rr_arbiter_nch
  import cpu_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic            mode,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW:0] cand;
  logic          found;

  // Walk candidates in search order; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = (mode == MODE_RR) ? ({1'b0, ptr} + (SELW+1)'(i)) : (SELW+1)'(i);
      if (cand >= (SELW+1)'(NCH)) cand = cand - (SELW+1)'(NCH);
      if (!found && req[cand[SELW-1:0]]) begin
        found                   = 1'b1;
        grant[cand[SELW-1:0]]   = 1'b1;
        grant_idx               = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrated mux with a 1-entry registered output stage.
// Latency: word accepted at edge k is valid after edge k; 1 word/cycle with out_ready high.
// Backpressure: while full and out_ready low every in_ready is 0 and the output holds.
module mux_arb_nto1
  import cpu_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int NCH    = 4,
  localparam int SELW   = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_arb_nto1_if.slave  bus
);

  stage_e            state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0]    grant;
  logic [SELW-1:0]   grant_idx;
  logic              can_load;
  logic              xfer;
  logic              out_valid;

  rr_arbiter_nch #(.NCH(NCH)) u_arb (
    .req       (bus.in_valid),
    .mode      (bus.mode),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // rst_n gates in_ready so no producer believes a word was taken while the stage is held in reset.
  assign can_load     = !out_valid || bus.out_ready;
  assign bus.in_ready = grant & {NCH{can_load & rst_n}};
  assign xfer         = |bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
  end

  // Pointer advances on every transfer, in either mode, so a switch to round-robin resumes after the last winner.
  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      data_d   = bus.in_data[grant_idx*DWIDTH +: DWIDTH];
      sel_d    = grant_idx;
      rr_ptr_d = (grant_idx == SELW'(NCH-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N-to-1 registered multiplexer with valid/ready handshaking and selectable fixed-priority or round-robin arbitration. It generalises the datapath 2:1 select muxes into a shared-resource front end, for example instruction fetch vs. load/store access to a single memory port, or writeback source merging. It adds one output register stage, which holds a granted word until the consumer accepts it.

## Interface
- DWIDTH, 32, data width of every channel.
- NCH, 4, number of input channels, legal range 2..16.
- SELW, $clog2(NCH), width of the channel index. Derived; never overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_data  input  NCH*DWIDTH  channel i occupies bits [i*DWIDTH +: DWIDTH].
- in_valid  input  NCH  channel i presents a word.
- in_ready  output  NCH  channel i's word is accepted this cycle.
- mode  input  1  0 = fixed priority, lowest index wins; 1 = round-robin.
- out_data  output  DWIDTH  registered winning word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_sel hold an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.

## Operation
- Output stage is a 1-entry buffer with two states.
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- can_load = !out_valid | out_ready. The stage may take a new word when empty or when the current word drains in this same cycle.
- Arbitration is combinational over in_valid and runs every cycle. The result is a one-hot grant vector; at most one bit is set.
  - mode 0: grant = lowest-index asserted in_valid.
  - mode 1: grant = first asserted in_valid at or after rr_ptr, searching upward and wrapping NCH-1 -> 0.
- in_ready = grant & {NCH{can_load}}. in_ready never asserts for a channel whose in_valid is low.
- Transfer on channel g (in_valid[g] & in_ready[g]):
  - out_data <= word of channel g;
  - out_sel <= g;
  - out_valid <= 1.
- If the stage drains with no transfer in the same cycle, out_valid <= 0. out_data and out_sel hold their old values.
- rr_ptr (SELW bits) updates only on a transfer.
  - It becomes g+1, wrapping to 0 when g = NCH-1.
  - It is kept in both modes, so switching mode 0 -> 1 resumes from the last winner + 1.
- mode is sampled every cycle. A change affects only the arbitration in that cycle and has no other side effects.
- No valid requests: grant = 0, in_ready = 0, rr_ptr holds.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.

## Timing
- Reset values: out_valid 0, out_data 0, out_sel 0, rr_ptr 0, in_ready 0.
  - in_ready is combinational from the registers, so it is 0 while out_valid = 0 and no request is pending.
- Asserting rst_n low mid-transfer discards the buffered word immediately and asynchronously.
- Latency: a word accepted at edge k appears on out_data with out_valid high after edge k.
- Throughput: one word per cycle when out_ready is held high.
- Back-pressure:
  - While FULL and out_ready = 0: all in_ready = 0, and out_data/out_sel are held unchanged.
  - Simultaneous drain and load in one cycle keeps out_valid at 1 with the new data.
- Combinational paths: in_valid, mode and out_ready feed in_ready. No path runs from in_* to out_*.

## Structure
- A shared package, cpu_pkg, holds:
  - the DWIDTH default;
  - the MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants;
  - a clog2 function, if the toolchain lacks $clog2.
- Sub-module rr_arbiter_nch contains:
  - parameter NCH;
  - inputs req[NCH], mode, ptr[SELW];
  - outputs grant[NCH] (one-hot) and grant_idx[SELW].
- The top level holds the output register, rr_ptr and the data select, indexed part-select by grant_idx.

## Test plan
- Reset: hold rst_n = 0 with random inputs. Require out_valid = 0, out_data = 0, out_sel = 0 and in_ready = 0. Release; with no requests, the outputs stay at these values.
- Fixed priority: NCH = 4, mode = 0, in_valid = 4'b1010, out_ready = 1. Require in_ready = 4'b0010 each cycle, out_sel = 1, and channel 3 never served.
- Round-robin:
  - Stimulus: mode = 1, in_valid = 4'b1111, data = 0xA0+i, out_ready = 1.
  - Required: out_sel sequence 0,1,2,3,0, with out_data 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
  - Also: with in_valid = 4'b1001 and the pointer at 1, the grant goes to channel 3.
- Back-pressure:
  - Load 0x55 from channel 2, then hold out_ready = 0 for 5 cycles.
  - Require out_data = 0x55, out_sel = 2 and in_ready = 0 throughout.
  - Raise out_ready: the next word loads in the same cycle and out_valid stays 1.
- Mode switch: in mode 0, serve channel 2 (rr_ptr -> 3), then set mode = 1 with in_valid = 4'b1111. Require the next grant to be channel 3.
- Mid-operation reset: assert rst_n low asynchronously while out_valid = 1. Require out_valid = 0 before the next clock edge, and rr_ptr = 0 after release, so the first round-robin grant with all channels requesting is channel 0.
